// File: rtl/lzd_norm_shift.sv
// Three-stage normalizing barrel shifter: moves the leading one of an operand to the MSB
// using the LZD count and reports its bit index. `LZD_NORM_CHECK_EN adds a sticky chk_fail flag.
module lzd_norm_shift #(
  parameter int WIDTH = 48,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic             in_nz,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mant,
  output logic [CNT_W-1:0] out_exp,
  output logic             out_zero,
  output logic             out_err
`ifdef LZD_NORM_CHECK_EN
  ,
  output logic             chk_fail
`endif
);

  // Count split MSB-first into three slices; the coarsest slice absorbs any remainder.
  localparam int W3 = CNT_W / 3;
  localparam int W2 = (CNT_W - W3) / 2;
  localparam int W1 = CNT_W - W2 - W3;
  localparam int RW = W2 + W3;
  localparam logic [CNT_W-1:0] TOP_EXP = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0] d,
                                           input logic [CNT_W-1:0] sh);
    return d << sh;
  endfunction

  logic             en1, en2, en3;
  logic             vld_p1, vld_p2, vld_p3;
  logic [WIDTH-1:0] mant_p1, mant_p2;
  logic [RW-1:0]    cnt_p1;
  logic [W3-1:0]    cnt_p2;
  logic [CNT_W-1:0] exp_p1, exp_p2;
  logic             zero_p1, zero_p2, err_p1, err_p2;
  logic             in_bad, in_zero;
  logic [CNT_W-1:0] sh1, sh2, sh3;

  assign en3       = ~vld_p3 | out_ready;
  assign en2       = ~vld_p2 | en3;
  assign en1       = ~vld_p1 | en2;
  assign in_ready  = en1;
  assign out_valid = vld_p3;

  assign in_bad  = int'(in_cnt) >= WIDTH;
  assign in_zero = ~in_nz | in_bad;
  assign sh1     = {in_cnt[CNT_W-1 -: W1], {RW{1'b0}}};
  assign sh2     = CNT_W'({cnt_p1[RW-1 -: W2], {W3{1'b0}}});
  assign sh3     = CNT_W'(cnt_p2);

  // Stage 1 and stage 2 datapath: don't-care while their valid bit is low.
  always_ff @(posedge clk) begin
    if (en1) begin
      mant_p1 <= in_zero ? '0 : shl(in_data, sh1);
      cnt_p1  <= in_zero ? '0 : in_cnt[RW-1:0];
      exp_p1  <= in_zero ? '0 : TOP_EXP - in_cnt;
      zero_p1 <= in_zero;
      err_p1  <= in_nz & in_bad;
    end
    if (en2) begin
      mant_p2 <= shl(mant_p1, sh2);
      cnt_p2  <= cnt_p1[W3-1:0];
      exp_p2  <= exp_p1;
      zero_p2 <= zero_p1;
      err_p2  <= err_p1;
    end
  end

  // Valid chain and stage 3, which doubles as the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      vld_p3   <= 1'b0;
      out_mant <= '0;
      out_exp  <= '0;
      out_zero <= 1'b0;
      out_err  <= 1'b0;
    end else begin
      if (en1) vld_p1 <= in_valid;
      if (en2) vld_p2 <= vld_p1;
      if (en3) begin
        vld_p3   <= vld_p2;
        out_mant <= shl(mant_p2, sh3);
        out_exp  <= exp_p2;
        out_zero <= zero_p2;
        out_err  <= err_p2;
      end
    end
  end

`ifdef LZD_NORM_CHECK_EN
  // A retiring nonzero result must carry a set MSB and an in-range exponent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_fail <= 1'b0;
    end else if (vld_p3 & out_ready & ~out_zero &
                 (~out_mant[WIDTH-1] | (int'(out_exp) >= WIDTH))) begin
      chk_fail <= 1'b1;
    end
  end
`endif

endmodule
